req_latch4: RTL and testbench

//  Front-end stage feeding the 4-to-2 priority encoder. Captures rising edges on

---
 rtl/req_latch4.sv | 119 +++++++++++
 tb/tb_req_latch4.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/req_latch4.sv
// req_latch4: captures rising edges on four request lines into sticky pending
// bits, clears one bit per acknowledge and counts requests lost to an already
// pending bit. Define REQ_SYNC_EN to add a two-flop synchronizer on req.
//
// Per-bit state (the pend bit itself):
//   state   | meaning
//   IDLE    | no outstanding request on this line
//   PENDING | request captured, waiting for ack with matching ack_idx

module req_latch4 #(
  parameter int OVF_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             ack,
  input  logic [1:0]       ack_idx,
  output logic [3:0]       pend,
  output logic             valid,
  output logic [OVF_W-1:0] ovf_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } bit_state_e;

  localparam logic [OVF_W+2:0] CNT_MAX = {3'b000, {OVF_W{1'b1}}};

  bit_state_e       state_q [4];
  bit_state_e       state_d [4];
  logic [3:0]       req_smp;
  logic [3:0]       r0;
  logic [3:0]       r1;
  logic [3:0]       rise;
  logic [3:0]       ack_hit;
  logic [3:0]       lost;
  logic [3:0]       pend_d;
  logic [2:0]       lost_n;
  logic [OVF_W+2:0] cnt_sum;
  logic [OVF_W-1:0] cnt_d;
  logic             valid_d;

`ifdef REQ_SYNC_EN
  logic [3:0] s1;
  logic [3:0] s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= req;
      s2 <= s1;
    end
  end

  assign req_smp = s2;
`else
  assign req_smp = req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
    end else begin
      r0 <= req_smp;
      r1 <= r0;
    end
  end

  // A set from a fresh rise beats a same-cycle ack on the same bit.
  always_comb begin
    ack_hit = '0;
    if (ack) ack_hit[ack_idx] = 1'b1;
    rise = r0 & ~r1;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      lost[i]    = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (rise[i]) state_d[i] = PENDING;
        end
        PENDING: begin
          if (rise[i]) lost[i] = ~ack_hit[i];
          else if (ack_hit[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
      pend_d[i] = (state_d[i] == PENDING);
    end
    valid_d = |pend_d;
  end

  always_comb begin
    lost_n  = 3'(lost[0]) + 3'(lost[1]) + 3'(lost[2]) + 3'(lost[3]);
    cnt_sum = {3'b000, ovf_cnt} + (OVF_W+3)'(lost_n);
    if (cnt_sum > CNT_MAX) cnt_d = {OVF_W{1'b1}};
    else                   cnt_d = cnt_sum[OVF_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) state_q[i] <= IDLE;
      valid   <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
      valid   <= valid_d;
      ovf_cnt <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) pend[i] = (state_q[i] == PENDING);
  end

endmodule

// File: tb/tb_req_latch4.sv
// Directed bench for req_latch4: a default-width instance and an OVF_W=2
// instance share all stimulus so counter saturation is seen on both.

module tb_req_latch4;

`ifdef REQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] ack_idx;
  logic [3:0] pend;
  logic       valid;
  logic [3:0] ovf_cnt;
  logic [3:0] pend2;
  logic       valid2;
  logic [1:0] ovf_cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  req_latch4 #(.OVF_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .ack_idx(ack_idx),
    .pend(pend), .valid(valid), .ovf_cnt(ovf_cnt)
  );

  req_latch4 #(.OVF_W(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .ack_idx(ack_idx),
    .pend(pend2), .valid(valid2), .ovf_cnt(ovf_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input logic [1:0] idx);
    ack     = 1'b1;
    ack_idx = idx;
    step(1);
    ack     = 1'b0;
  endtask

  task automatic pulse1(input int n);
    for (int k = 0; k < n; k++) begin
      req = 4'b0010;
      step(1);
      req = 4'b0000;
      step(1);
    end
    step(LAT + 1);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    ack     = 1'b0;
    ack_idx = 2'd0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_pend", pend, 4'b0000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ovf", ovf_cnt, 4'd0);

    // single held request, latency and ack
    req = 4'b0100;
    step(LAT - 1);
    chk("lat_early_pend", pend, 4'b0000);
    step(1);
    chk("lat_pend", pend, 4'b0100);
    chk("lat_valid", valid, 1'b1);
    step(3);
    chk("hold_pend", pend, 4'b0100);
    chk("hold_ovf", ovf_cnt, 4'd0);
    do_ack(2'd2);
    chk("ack2_pend", pend, 4'b0000);
    chk("ack2_valid", valid, 1'b0);
    req = 4'b0000;
    step(LAT + 1);

    // two requests, acked one at a time, then a stray ack
    req = 4'b1001;
    step(LAT);
    chk("two_pend", pend, 4'b1001);
    do_ack(2'd3);
    chk("ack3_pend", pend, 4'b0001);
    chk("ack3_valid", valid, 1'b1);
    do_ack(2'd0);
    chk("ack0_pend", pend, 4'b0000);
    chk("ack0_valid", valid, 1'b0);
    do_ack(2'd1);
    chk("stray_ack_pend", pend, 4'b0000);
    chk("stray_ack_valid", valid, 1'b0);
    req = 4'b0000;
    step(LAT + 1);
    chk("no_lost_ovf", ovf_cnt, 4'd0);

    // lost requests on a pending bit, saturation of the narrow counter
    req = 4'b0010;
    step(LAT);
    chk("p1_pend", pend, 4'b0010);
    req = 4'b0000;
    step(LAT + 1);
    pulse1(3);
    chk("lost3_ovf", ovf_cnt, 4'd3);
    chk("lost3_ovf_w2", ovf_cnt2, 2'd3);
    chk("lost3_pend", pend, 4'b0010);
    pulse1(3);
    chk("lost6_ovf", ovf_cnt, 4'd6);
    chk("lost6_ovf_w2_sat", ovf_cnt2, 2'd3);

    // rise and ack on the same pending bit: set wins, nothing lost
    req = 4'b0100;
    step(LAT);
    req = 4'b0000;
    step(LAT + 1);
    chk("p2_pend", pend, 4'b0110);
    req = 4'b0100;
    step(LAT - 1);
    do_ack(2'd2);
    req = 4'b0000;
    chk("collide_pend", pend, 4'b0110);
    chk("collide_ovf", ovf_cnt, 4'd6);
    step(LAT + 1);
    do_ack(2'd2);
    chk("ack_after_collide", pend, 4'b0010);

    // all four lines rising, counter climbs to and holds at 15
    req = 4'b1111;
    step(LAT);
    chk("all_pend", pend, 4'b1111);
    chk("all_ovf_7", ovf_cnt, 4'd7);
    req = 4'b0000;
    step(LAT + 1);
    req = 4'b1111;
    step(LAT);
    chk("all_ovf_11", ovf_cnt, 4'd11);
    chk("all_pend_kept", pend, 4'b1111);
    req = 4'b0000;
    step(LAT + 1);
    req = 4'b1111;
    step(LAT);
    chk("all_ovf_15", ovf_cnt, 4'd15);
    req = 4'b0000;
    step(LAT + 1);
    req = 4'b1111;
    step(LAT);
    chk("all_ovf_sat", ovf_cnt, 4'd15);
    chk("all_ovf_w2_sat", ovf_cnt2, 2'd3);
    req = 4'b0000;
    step(LAT + 1);

    // async reset mid-run with pend=1010
    do_ack(2'd2);
    do_ack(2'd0);
    chk("pre_rst_pend", pend, 4'b1010);
    rst = 1'b1;
    #1;
    chk("async_rst_pend", pend, 4'b0000);
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_ovf", ovf_cnt, 4'd0);
    chk("async_rst_ovf_w2", ovf_cnt2, 2'd0);
    step(1);
    rst = 1'b0;
    step(LAT + 1);
    chk("post_rst_pend", pend, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
